adder_sweep_checker: RTL

Synthesizable stimulus/response engine that drives an N-bit ripple adder DUT exhaustively and checks its results in hardware. It generates every (a, b, c_in) combination, waits a settle interval, then compares the DUT's sum/carry against an internal golden sum. It reports error count, first-failure capture and pass/done status. It sits opposite the adder (generator on the inputs, checker on the outputs) so adder variants can be qualified on silicon or FPGA without a simulator.

---
 rtl/adder_sweep_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/adder_sweep_checker.sv
// Exhaustive stimulus/response checker for an N-bit adder: drives every (a, b, cin) combination and compares the result against a golden sum.
// Optional build macro ADDER_CHK_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module adder_sweep_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  output logic                 dut_cin,
  input  logic [WIDTH-1:0]     dut_sum,
  input  logic                 dut_cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [2*WIDTH+1:0]   vec_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic                 fail_cin,
  output logic                 fail_cout,
  output logic [WIDTH-1:0]     fail_sum
);

  localparam int VW = 2*WIDTH + 1;
  localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [VW-1:0]   vec_idx_reg;
  logic [3:0]      settle_cnt_reg;
  logic            first_fail_reg;

  logic [WIDTH:0]  golden;
  logic            mismatch;
  logic            last_vec;
  logic            settle_last;

  // Golden is taken from the registered operands so it always matches what the DUT sees.
  assign golden      = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
  assign mismatch    = ({dut_cout, dut_sum} != golden);
  assign last_vec    = &vec_idx_reg;
  assign settle_last = (settle_cnt_reg == SETTLE_LAST);

  assign busy = (state_reg == S_DRIVE) || (state_reg == S_SETTLE) || (state_reg == S_CHECK);
  assign done = (state_reg == S_DONE);
  assign pass = (state_reg == S_DONE) && (err_count == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_DRIVE;
      end
      S_DRIVE: begin
        if (SETTLE == 0) state_next = S_CHECK;
        else             state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_last) state_next = S_CHECK;
      end
      S_CHECK: begin
`ifdef ADDER_CHK_STOP_ON_FAIL_EN
        if (mismatch && !first_fail_reg) state_next = S_DONE;
        else if (last_vec)               state_next = S_DONE;
        else                             state_next = S_DRIVE;
`else
        if (last_vec) state_next = S_DONE;
        else          state_next = S_DRIVE;
`endif
      end
      S_DONE: begin
        if (start) state_next = S_DRIVE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_idx_reg    <= '0;
      settle_cnt_reg <= '0;
      first_fail_reg <= 1'b0;
      dut_a          <= '0;
      dut_b          <= '0;
      dut_cin        <= 1'b0;
      err_count      <= '0;
      vec_count      <= '0;
      fail_a         <= '0;
      fail_b         <= '0;
      fail_cin       <= 1'b0;
      fail_cout      <= 1'b0;
      fail_sum       <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec_idx_reg    <= '0;
            first_fail_reg <= 1'b0;
            err_count      <= '0;
            vec_count      <= '0;
            fail_a         <= '0;
            fail_b         <= '0;
            fail_cin       <= 1'b0;
            fail_cout      <= 1'b0;
            fail_sum       <= '0;
          end
        end
        S_DRIVE: begin
          // Index layout: cin is the MSB, then a, then b in the low bits.
          dut_cin        <= vec_idx_reg[VW-1];
          dut_a          <= vec_idx_reg[2*WIDTH-1:WIDTH];
          dut_b          <= vec_idx_reg[WIDTH-1:0];
          settle_cnt_reg <= '0;
        end
        S_SETTLE: begin
          settle_cnt_reg <= settle_cnt_reg + 4'd1;
        end
        S_CHECK: begin
          vec_count <= vec_count + 1'b1;
          if (mismatch) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (!first_fail_reg) begin
              first_fail_reg <= 1'b1;
              fail_a         <= dut_a;
              fail_b         <= dut_b;
              fail_cin       <= dut_cin;
              fail_cout      <= dut_cout;
              fail_sum       <= dut_sum;
            end
          end
          if (state_next == S_DRIVE) vec_idx_reg <= vec_idx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
